// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory port controller.
// Optional round-robin arbitration is selected with MEM_PORT_RR_ARB_EN.
package mem_port_ctrl_pkg;

  typedef enum logic {
    MPC_IDLE = 1'b0,
    MPC_XFER = 1'b1
  } mpc_state_e;

  // Index/count width that stays legal when the range has a single entry.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Combinational channel arbiter: fixed priority (highest index wins) by default,
// round-robin with a registered pointer when MEM_PORT_RR_ARB_EN is defined.
module mem_port_arb
  import mem_port_ctrl_pkg::*;
#(
  parameter int  NUM_CH = 2,
  localparam int IDX_W  = width_of(NUM_CH)
) (
`ifdef MEM_PORT_RR_ARB_EN
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
`endif
  input  logic [NUM_CH-1:0] req,
  output logic              any,
  output logic [IDX_W-1:0]  gnt
);

  assign any = |req;

`ifdef MEM_PORT_RR_ARB_EN
  logic [IDX_W-1:0] ptr_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    idx = 0;
    gnt = ptr_q;
    // Walk from the farthest candidate back to ptr_q so the nearest one wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_CH;
      if (req[idx]) gnt = IDX_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (adv) begin
      ptr_q <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + IDX_W'(1);
    end
  end
`else
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i]) gnt = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/mem_port_ctrl.sv
// N-channel byte-serial memory port controller: arbitrates requesters onto one
// 8-bit bus and serialises little-endian transfers. Macro: MEM_PORT_RR_ARB_EN.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int  NUM_CH    = 2,
  parameter int  ADDR_W    = 32,
  parameter int  MAX_BYTES = 4,
  localparam int DW        = 8 * MAX_BYTES,
  localparam int SZ_W      = width_of(MAX_BYTES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*SZ_W-1:0]   size_i,
  input  logic [NUM_CH*DW-1:0]     wdata_i,
  output logic [NUM_CH-1:0]        done_o,
  output logic [DW-1:0]            rdata_o,
  output logic                     busy_o,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr
);

  localparam int IDX_W = width_of(NUM_CH);
  localparam int CNT_W = SZ_W + 1;

  mpc_state_e        state_q, state_d;
  logic [IDX_W-1:0]  gnt, g_q;
  logic              any_req;
  logic [NUM_CH-1:0] req_m;
  logic              we_q;
  logic [SZ_W-1:0]   size_q;
  logic [CNT_W-1:0]  iss_q, cap_q, n_bytes, cap_next;
  logic              cap_pend_q;
  logic [DW-1:0]     wsh_q, rdata_q;
  logic [NUM_CH-1:0] done_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic              grant, issuing, issue_now, last_issue, finish;

  // A channel being told "done" this cycle must not win a fresh grant.
  assign req_m = req_i & ~done_q;

  mem_port_arb #(.NUM_CH(NUM_CH)) u_arb (
`ifdef MEM_PORT_RR_ARB_EN
    .clk (clk),
    .rst (rst),
    .adv (grant),
`endif
    .req (req_m),
    .any (any_req),
    .gnt (gnt)
  );

  assign n_bytes    = CNT_W'(size_q) + CNT_W'(1);
  assign issuing    = (state_q == MPC_XFER) && (iss_q < n_bytes);
  assign issue_now  = issuing && rdy;
  assign last_issue = issue_now && (iss_q == n_bytes - CNT_W'(1));
  assign cap_next   = cap_q + CNT_W'(cap_pend_q);
  assign grant      = (state_q == MPC_IDLE) && rdy && any_req;
  // Reads finish once the last byte is (or already was) captured.
  assign finish     = (state_q == MPC_XFER) && rdy &&
                      (we_q ? last_issue : (cap_next == n_bytes));

  always_comb begin
    state_d = state_q;
    busy_o  = (state_q == MPC_XFER);
    mem_wr  = issue_now && we_q;
    case (state_q)
      MPC_IDLE: if (grant)  state_d = MPC_XFER;
      MPC_XFER: if (finish) state_d = MPC_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= MPC_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q        <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      iss_q      <= '0;
      cap_q      <= '0;
      cap_pend_q <= 1'b0;
      wsh_q      <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      mem_a_q    <= '0;
    end else begin
      done_q <= '0;
      if (finish) done_q[g_q] <= 1'b1;
      cap_pend_q <= issue_now && !we_q;
      if (grant) begin
        g_q     <= gnt;
        we_q    <= we_i[gnt];
        size_q  <= size_i[int'(gnt)*SZ_W +: SZ_W];
        mem_a_q <= addr_i[int'(gnt)*ADDR_W +: ADDR_W];
        wsh_q   <= wdata_i[int'(gnt)*DW +: DW];
        iss_q   <= '0;
        cap_q   <= '0;
        rdata_q <= '0;
      end else begin
        // The bus holds the last address and byte once issue is complete.
        if (issue_now) begin
          iss_q <= iss_q + CNT_W'(1);
          if (!last_issue) begin
            mem_a_q <= mem_a_q + ADDR_W'(1);
            wsh_q   <= wsh_q >> 8;
          end
        end
        // Capture ignores rdy: the byte on mem_din is only valid this cycle.
        if (cap_pend_q) begin
          rdata_q[8*int'(cap_q[SZ_W-1:0]) +: 8] <= mem_din;
          cap_q <= cap_next;
        end
      end
    end
  end

  assign done_o   = done_q;
  assign rdata_o  = rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = wsh_q[7:0];

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed scenarios plus randomized
// transfers checked against a byte-addressed reference memory model.
module tb_mem_port_ctrl;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int MAX_BYTES = 4;
  localparam int DW = 32;
  localparam int SZ_W = 2;
`ifdef MEM_PORT_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                     clk, rst, rdy;
  logic [NUM_CH-1:0]        req_i, we_i;
  logic [NUM_CH*ADDR_W-1:0] addr_i;
  logic [NUM_CH*SZ_W-1:0]   size_i;
  logic [NUM_CH*DW-1:0]     wdata_i;
  logic [NUM_CH-1:0]        done_o;
  logic [DW-1:0]            rdata_o;
  logic                     busy_o;
  logic [7:0]               mem_din, mem_dout;
  logic [ADDR_W-1:0]        mem_a;
  logic                     mem_wr;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  ram     [logic [17:0]];
  logic [7:0]  exp_mem [logic [17:0]];
  logic [39:0] wr_log  [$];
  logic [31:0] rd_log  [$];
  int          done_cnt [NUM_CH];

  mem_port_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .size_i(size_i), .wdata_i(wdata_i), .done_o(done_o),
    .rdata_o(rdata_o), .busy_o(busy_o), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fill(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'h0, a[17:16]} ^ 8'h5A;
  endfunction

  // Bus-side RAM: one-cycle read latency, writes on mem_wr.
  always @(posedge clk) begin
    logic [7:0] b;
    b = ram.exists(mem_a[17:0]) ? ram[mem_a[17:0]] : fill(mem_a[17:0]);
    mem_din <= b;
    if (mem_wr) begin
      ram[mem_a[17:0]] = mem_dout;
      wr_log.push_back({mem_a, mem_dout});
    end
    if (busy_o && rdy && !mem_wr) rd_log.push_back(mem_a);
    for (int c = 0; c < NUM_CH; c++) if (done_o[c]) done_cnt[c]++;
  end

  // Reference model: expected memory contents from the stimulus alone.
  function automatic logic [7:0] exp_rd(input logic [17:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : fill(a);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int size);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i <= size; i++) r[8*i +: 8] = exp_rd(18'(a + 32'(i)));
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input int size, input logic [31:0] wd);
    for (int i = 0; i <= size; i++) exp_mem[18'(a + 32'(i))] = wd[8*i +: 8];
  endfunction

  function automatic int write_diffs(input logic [31:0] a, input int size, input logic [31:0] wd);
    int d;
    d = 0;
    if (wr_log.size() != size + 1) return 100 + wr_log.size();
    for (int i = 0; i <= size; i++)
      if (wr_log[i] !== {a + 32'(i), wd[8*i +: 8]}) d++;
    return d;
  endfunction

  function automatic bit rd_walk_ok(input logic [31:0] a, input int size);
    if (rd_log.size() == 0) return 1'b0;
    if (rd_log[0] !== a) return 1'b0;
    for (int i = 1; i < rd_log.size(); i++)
      if (!(rd_log[i] === rd_log[i-1] || rd_log[i] === rd_log[i-1] + 32'd1)) return 1'b0;
    return rd_log[rd_log.size()-1] === a + 32'(size);
  endfunction

  // One transfer on one channel; rdy is held low for k in [lo_at, lo_at+lo_len),
  // otherwise high with probability rdy_pct. Returns when done_o is seen.
  task automatic do_xfer(input int ch, input bit we, input logic [31:0] addr, input int size,
                         input logic [31:0] wd, input int rdy_pct, input int lo_at, input int lo_len,
                         output int lat, output logic [1:0] dv, output logic [31:0] rd,
                         output logic bz, output bit tmo);
    lat = 0; dv = '0; rd = '0; bz = 1'b1; tmo = 1'b1;
    @(negedge clk);
    wr_log.delete();
    rd_log.delete();
    req_i[ch] = 1'b1;
    we_i[ch] = we;
    addr_i[ch*ADDR_W +: ADDR_W] = addr;
    size_i[ch*SZ_W +: SZ_W] = 2'(size);
    wdata_i[ch*DW +: DW] = wd;
    rdy = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done_o !== 2'b00) begin
        lat = k; dv = done_o; rd = rdata_o; bz = busy_o; tmo = 1'b0;
        break;
      end
      if (k >= lo_at && k < lo_at + lo_len) rdy = 1'b0;
      else rdy = ($urandom_range(99) < rdy_pct);
    end
    req_i[ch] = 1'b0;
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    req_i = '0; we_i = '0; addr_i = '0; size_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk);
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 2'b00) $display("FAIL reset_done got %b want 00", done_o); else n_pass++;
    n_total++; if (rdata_o !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata_o); else n_pass++;
    n_total++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr got %0b want 0", mem_wr); else n_pass++;
    n_total++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a got %h want 0", mem_a); else n_pass++;
    n_total++; if (mem_dout !== 8'h0) $display("FAIL reset_mem_dout got %h want 0", mem_dout); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (busy_o !== 1'b0) $display("FAIL idle_busy got %0b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_read_basic();
    int lat; logic [1:0] dv; logic [31:0] rd; logic bz; bit tmo;
    do_xfer(0, 1'b1, 32'h100, 3, 32'h44332211, 100, 0, 0, lat, dv, rd, bz, tmo);
    n_total++; if (write_diffs(32'h100, 3, 32'h44332211) !== 0) $display("FAIL seed_write diffs %0d want 0", write_diffs(32'h100, 3, 32'h44332211)); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL seed_write_lat got %0d want 5", lat); else n_pass++;
    model_write(32'h100, 3, 32'h44332211);
    do_xfer(1, 1'b0, 32'h100, 3, 32'h0, 100, 0, 0, lat, dv, rd, bz, tmo);
    n_total++; if (lat !== 6) $display("FAIL read_lat got %0d want 6", lat); else n_pass++;
    n_total++; if (dv !== 2'b10) $display("FAIL read_done got %b want 10", dv); else n_pass++;
    n_total++; if (rd !== 32'h44332211) $display("FAIL read_data got %h want 44332211", rd); else n_pass++;
    n_total++; if (bz !== 1'b0) $display("FAIL read_busy_at_done got %0b want 0", bz); else n_pass++;
    n_total++;
    if (rd_log.size() < 4) $display("FAIL read_addr_count got %0d want >=4", rd_log.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      n_total++;
      if (rd_log[i] !== 32'h100 + 32'(i)) $display("FAIL read_addr%0d got %h want %h", i, rd_log[i], 32'h100 + 32'(i));
      else n_pass++;
    end
    @(negedge clk);
    n_total++; if (rdata_o !== 32'h44332211) $display("FAIL rdata_hold got %h want 44332211", rdata_o); else n_pass++;
    n_total++; if (done_o !== 2'b00) $display("FAIL done_pulse_width got %b want 00", done_o); else n_pass++;
  endtask

  task automatic test_write_pause();
    int lat; logic [1:0] dv; logic [31:0] rd; logic bz; bit tmo;
    do_xfer(0, 1'b1, 32'h30000, 0, 32'h41, 100, 1, 3, lat, dv, rd, bz, tmo);
    n_total++; if (wr_log.size() !== 1) $display("FAIL pause_write_count got %0d want 1", wr_log.size()); else n_pass++;
    n_total++; if (write_diffs(32'h30000, 0, 32'h41) !== 0) $display("FAIL pause_write_byte diffs %0d want 0", write_diffs(32'h30000, 0, 32'h41)); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL pause_lat got %0d want 5", lat); else n_pass++;
    n_total++; if (dv !== 2'b01) $display("FAIL pause_done got %b want 01", dv); else n_pass++;
    n_total++; if (rd !== 32'h0) $display("FAIL write_rdata got %h want 0", rd); else n_pass++;
    model_write(32'h30000, 0, 32'h41);
  endtask

  task automatic test_back_to_back();
    int kq[$];
    logic [1:0] dq[$];
    logic [1:0] first_w, want;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_log.delete();
    we_i = 2'b11;
    addr_i = {32'h32000, 32'h31000};
    size_i = '0;
    wdata_i = {32'hB1, 32'hA0};
    rdy = 1'b1;
    req_i = 2'b11;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_o !== 2'b00) begin kq.push_back(k); dq.push_back(done_o); end
      if (dq.size() == 8) break;
    end
    req_i = '0;
    // After reset the round-robin pointer favours ch0; fixed priority favours ch1.
    first_w = RR ? 2'b01 : 2'b10;
    n_total++; if (dq.size() !== 8) $display("FAIL arb_rounds got %0d want 8", dq.size()); else n_pass++;
    for (int i = 0; i < dq.size(); i++) begin
      want = (i % 2 == 0) ? first_w : ~first_w;
      n_total++;
      if (dq[i] !== want) $display("FAIL arb_order%0d got %b want %b", i, dq[i], want); else n_pass++;
    end
    if (kq.size() > 0) begin
      n_total++; if (kq[0] !== 2) $display("FAIL arb_first_lat got %0d want 2", kq[0]); else n_pass++;
    end
    for (int i = 1; i < kq.size(); i++) begin
      n_total++;
      if (kq[i] - kq[i-1] !== 2) $display("FAIL arb_gap%0d got %0d want 2", i, kq[i] - kq[i-1]); else n_pass++;
    end
    n_total++; if (wr_log.size() !== 8) $display("FAIL arb_writes got %0d want 8", wr_log.size()); else n_pass++;
    model_write(32'h31000, 0, 32'hA0);
    model_write(32'h32000, 0, 32'hB1);
  endtask

  task automatic test_boundary();
    int lat; logic [1:0] dv; logic [31:0] rd; logic bz; bit tmo;
    logic [31:0] want;
    want = {16'h0, exp_rd(18'h20000), exp_rd(18'h1FFFF)};
    do_xfer(1, 1'b0, 32'h1FFFF, 1, 32'h0, 100, 3, 1, lat, dv, rd, bz, tmo);
    n_total++; if (rd !== want) $display("FAIL boundary_data got %h want %h", rd, want); else n_pass++;
    n_total++; if (lat !== 5) $display("FAIL boundary_lat got %0d want 5", lat); else n_pass++;
    n_total++; if (dv !== 2'b10) $display("FAIL boundary_done got %b want 10", dv); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [1:0] dv; logic [31:0] rd; logic bz; bit tmo;
    int d0;
    @(negedge clk);
    req_i[0] = 1'b1; we_i[0] = 1'b1;
    addr_i[31:0] = 32'h3F000; size_i[1:0] = 2'd3; wdata_i[31:0] = 32'hDEADBEEF;
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (busy_o !== 1'b1) $display("FAIL abort_busy_before got %0b want 1", busy_o); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (mem_wr !== 1'b0) $display("FAIL abort_mem_wr got %0b want 0", mem_wr); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 2'b00) $display("FAIL abort_done got %b want 00", done_o); else n_pass++;
    rst = 1'b0;
    req_i[0] = 1'b0;
    d0 = done_cnt[0] + done_cnt[1];
    repeat (3) @(negedge clk);
    n_total++; if (done_cnt[0] + done_cnt[1] !== d0) $display("FAIL abort_no_done got %0d want %0d", done_cnt[0] + done_cnt[1], d0); else n_pass++;
    do_xfer(0, 1'b1, 32'h3F100, 1, 32'h00007E5C, 100, 0, 0, lat, dv, rd, bz, tmo);
    n_total++; if (lat !== 3) $display("FAIL after_abort_lat got %0d want 3", lat); else n_pass++;
    n_total++; if (write_diffs(32'h3F100, 1, 32'h00007E5C) !== 0) $display("FAIL after_abort_writes diffs %0d want 0", write_diffs(32'h3F100, 1, 32'h00007E5C)); else n_pass++;
    model_write(32'h3F100, 1, 32'h00007E5C);
  endtask

  task automatic test_hold_past_done();
    bit found;
    int c0;
    c0 = done_cnt[1];
    found = 1'b0;
    @(negedge clk);
    req_i[1] = 1'b1; we_i[1] = 1'b1;
    addr_i[63:32] = 32'h3E000; size_i[3:2] = 2'd0; wdata_i[63:32] = 32'h5A;
    rdy = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_o !== 2'b00) begin found = 1'b1; break; end
    end
    n_total++; if (found !== 1'b1) $display("FAIL hold_done_seen got %0b want 1", found); else n_pass++;
    @(negedge clk);
    n_total++; if (busy_o !== 1'b0) $display("FAIL hold_regrant busy got %0b want 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 2'b00) $display("FAIL hold_done_again got %b want 00", done_o); else n_pass++;
    req_i[1] = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (done_cnt[1] - c0 !== 1) $display("FAIL hold_single_done got %0d want 1", done_cnt[1] - c0); else n_pass++;
    model_write(32'h3E000, 0, 32'h5A);
  endtask

  task automatic test_random();
    int lat; logic [1:0] dv; logic [31:0] rd; logic bz; bit tmo;
    int ch, size, pct, want_lat;
    bit we;
    logic [31:0] addr, wd, want_rd;
    for (int i = 0; i < 24; i++) begin
      ch = $urandom_range(NUM_CH - 1);
      we = 1'($urandom_range(1));
      size = $urandom_range(MAX_BYTES - 1);
      addr = 32'h10000 + 32'($urandom_range(16'hFF00));
      wd = $urandom;
      pct = (i % 2 == 0) ? 100 : 60;
      want_rd = we ? 32'h0 : model_read(addr, size);
      do_xfer(ch, we, addr, size, wd, pct, 0, 0, lat, dv, rd, bz, tmo);
      n_total++; if (tmo !== 1'b0) $display("FAIL rnd%0d_timeout", i); else n_pass++;
      n_total++; if (dv !== 2'(1 << ch)) $display("FAIL rnd%0d_done got %b want %b", i, dv, 2'(1 << ch)); else n_pass++;
      n_total++; if (rd !== want_rd) $display("FAIL rnd%0d_rdata got %h want %h", i, rd, want_rd); else n_pass++;
      if (we) begin
        n_total++;
        if (write_diffs(addr, size, wd) !== 0) $display("FAIL rnd%0d_writes diffs %0d want 0", i, write_diffs(addr, size, wd));
        else n_pass++;
        model_write(addr, size, wd);
      end else begin
        n_total++;
        if (rd_walk_ok(addr, size) !== 1'b1) $display("FAIL rnd%0d_addr_walk start %h size %0d", i, addr, size);
        else n_pass++;
      end
      if (pct == 100) begin
        want_lat = we ? size + 2 : size + 3;
        n_total++; if (lat !== want_lat) $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, want_lat); else n_pass++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) done_cnt[c] = 0;
    test_reset();
    test_read_basic();
    test_write_pause();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    test_hold_past_done();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
